md_unit: RTL

Multiply/divide unit of the Execute stage. Accepts mult/multu/div/divu/mthi/mtlo from E and holds the architectural HI/LO registers. It models fixed multi-cycle latency with a down-counter. Its `start` and `busy` outputs feed the hazard unit, which stalls D-stage multiply/divide instructions while either is high.

---
 rtl/md_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Execute-stage multiply/divide unit. Holds architectural HI/LO,
//            accepts mult/multu/div/divu/mthi/mtlo and models a fixed
//            multi-cycle latency with a down-counter.
// Ports    : clk, reset (sync, active-low)
//            md_en, md_op[2:0], A[31:0], B[31:0], req   -- E-stage request
//            start (comb), busy (reg)                   -- to hazard unit
//            HI[31:0], LO[31:0] (reg)                   -- architectural regs
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Arithmetic results, evaluated from the operands presented this cycle.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic        [31:0] quot_s, rem_s, quot_u, rem_u;
  logic               accept;

  // A zero divisor is replaced by one so the dividers never see /0; the
  // result is discarded in that case anyway (pend_wr stays low).
  assign divisor = (B == 32'd0) ? 32'd1 : B;

  assign prod_s = $signed(A) * $signed(B);
  assign prod_u = {32'd0, A} * {32'd0, B};
  // SV signed / truncates toward zero and % takes the dividend's sign.
  assign quot_s = $signed(A) / $signed(divisor);
  assign rem_s  = $signed(A) % $signed(divisor);
  assign quot_u = A / divisor;
  assign rem_u  = A % divisor;

  // Any E-stage effect requires a valid, unflushed request while idle.
  assign accept = md_en & ~req & ~busy_q;
  assign start  = accept & (md_op >= OP_MULT) & (md_op <= OP_DIVU);

  always_comb begin
    cnt_d     = cnt_q;
    pend_wr_d = pend_wr_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (cnt_q != 4'd0) begin
      // In-flight operation: new requests are ignored, commit on 1->0.
      cnt_d = cnt_q - 4'd1;
      if ((cnt_q == 4'd1) && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (accept) begin
      case (md_op)
        OP_MULT: begin
          cnt_d     = MULT_CNT;
          pend_wr_d = 1'b1;
          pend_hi_d = prod_s[63:32];
          pend_lo_d = prod_s[31:0];
        end
        OP_MULTU: begin
          cnt_d     = MULT_CNT;
          pend_wr_d = 1'b1;
          pend_hi_d = prod_u[63:32];
          pend_lo_d = prod_u[31:0];
        end
        OP_DIV: begin
          cnt_d     = DIV_CNT;
          pend_wr_d = (B != 32'd0);
          pend_hi_d = rem_s;
          pend_lo_d = quot_s;
        end
        OP_DIVU: begin
          cnt_d     = DIV_CNT;
          pend_wr_d = (B != 32'd0);
          pend_hi_d = rem_u;
          pend_lo_d = quot_u;
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end

    busy_d = (cnt_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      pend_wr_q <= 1'b0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      pend_wr_q <= pend_wr_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
`default_nettype wire
